// File: rtl/lt24_lcd_reset_sequencer_if.sv
// lt24_lcd_reset_sequencer_if: Avalon-MM register port of the LT24 reset sequencer
interface lt24_lcd_reset_sequencer_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lt24_lcd_reset_sequencer.sv
// lt24_lcd_reset_sequencer: LT24 panel hardware-reset sequencer (low, recover, ready) on Avalon-MM
// Defining LT24_RST_SEQ_IRQ_EN adds the IRQ_MASK bit and the irq output.
module lt24_lcd_reset_sequencer #(
   parameter int CNT_W      = 24,
   parameter int DEF_LOW    = 500,
   parameter int DEF_WAIT   = 6000000,
   parameter bit AUTO_START = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   lt24_lcd_reset_sequencer_if.slave bus,
   output logic lcd_reset_n,
   output logic lcd_ready
`ifdef LT24_RST_SEQ_IRQ_EN
   ,
   output logic irq
`endif
);
   typedef enum logic [1:0] {IDLE, ASSERT, RECOVER, READY} state_t;
   localparam state_t RST_STATE = AUTO_START ? ASSERT : IDLE;
   localparam logic [CNT_W-1:0] RST_LOW = CNT_W'(DEF_LOW);
   localparam logic [CNT_W-1:0] RST_WAIT = CNT_W'(DEF_WAIT);
   localparam logic [CNT_W-1:0] RST_CNT = (RST_LOW == '0) ? '0 : RST_LOW - 1'b1;
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, low_cycles, wait_cycles, low_ld, wait_ld;
   logic done, done_n, wr, start, clr, busy, unused_wd;
   logic [31:0] ctrl_rd;
   assign wr = bus.chipselect & ~bus.write_n;
   assign start = wr && bus.address == 2'd0 && bus.writedata[0];
   assign clr = wr && bus.address == 2'd1 && bus.writedata[2];
   assign busy = state == ASSERT || state == RECOVER;
   // a programmed count of 0 behaves as 1
   assign low_ld = (low_cycles == '0) ? '0 : low_cycles - 1'b1;
   assign wait_ld = (wait_cycles == '0) ? '0 : wait_cycles - 1'b1;
   assign done_n = (state == RECOVER && cnt == '0) | (done & ~clr);
   assign unused_wd = ^bus.writedata;
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      case (state)
         ASSERT: begin
            state_n = (cnt == '0) ? RECOVER : ASSERT;
            cnt_n = (cnt == '0) ? wait_ld : cnt - 1'b1;
         end
         RECOVER: begin
            state_n = (cnt == '0) ? READY : RECOVER;
            cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
         end
         default: begin
            state_n = start ? ASSERT : state;
            cnt_n = start ? low_ld : cnt;
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RST_STATE;
         cnt <= RST_CNT;
         low_cycles <= RST_LOW;
         wait_cycles <= RST_WAIT;
         done <= 1'b0;
         lcd_reset_n <= 1'b0;
         lcd_ready <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         if (wr && bus.address == 2'd2) low_cycles <= bus.writedata[CNT_W-1:0];
         if (wr && bus.address == 2'd3) wait_cycles <= bus.writedata[CNT_W-1:0];
         done <= done_n;
         lcd_reset_n <= state_n != ASSERT;
         lcd_ready <= state_n == READY;
      end
   end
`ifdef LT24_RST_SEQ_IRQ_EN
   logic irq_mask, irq_mask_n;
   assign irq_mask_n = (wr && bus.address == 2'd0) ? bus.writedata[2] : irq_mask;
   assign ctrl_rd = {29'b0, irq_mask, 2'b0};
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= 1'b0;
         irq <= 1'b0;
      end else begin
         irq_mask <= irq_mask_n;
         irq <= done_n & irq_mask_n;
      end
   end
`else
   assign ctrl_rd = '0;
`endif
   assign bus.readdata = (bus.address == 2'd0) ? ctrl_rd :
                         (bus.address == 2'd1) ? {29'b0, done, lcd_ready, busy} :
                         (bus.address == 2'd2) ? 32'(low_cycles) : 32'(wait_cycles);
endmodule
